// File: rtl/pipeline_debug_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_debug_ctrl
//
// Debug controller that sits between a UART command/response channel and a
// pipelined CPU. Single-byte commands start a free run ('r'), a single step
// ('s') or a register-file dump ('d'). A dump streams the 32 architectural
// registers out, 4 bytes each, LSB first.
//
// Configuration macro:
//   DBG_CYCLE_HEADER_EN - when defined, every dump is prefixed with the four
//                         bytes of o_cycle_count (LSB first), 132 bytes total.
//                         When undefined, a dump is the 128 register bytes.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   i_cmd_valid    in   command byte present
//   i_cmd[7:0]     in   command byte ('r' 0x72, 's' 0x73, 'd' 0x64)
//   o_cmd_ready    out  command accepted when valid & ready (IDLE only)
//   i_halt         in   pipeline retired a HALT instruction
//   o_pipe_enable  out  global enable for PC and pipeline registers
//   i_rf_regs      in   flattened register file, reg n at [32n+31:32n]
//   o_tx_data[7:0] out  dump byte to UART TX
//   o_tx_valid     out  dump byte valid
//   i_tx_ready     in   UART TX can accept a byte
//   o_cycle_count  out  number of enabled pipeline cycles (wraps)
//   o_halted       out  sticky: program reached HALT
// ---------------------------------------------------------------------------
module pipeline_debug_ctrl (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cmd_valid,
  input  logic [7:0]    i_cmd,
  output logic          o_cmd_ready,
  input  logic          i_halt,
  output logic          o_pipe_enable,
  input  logic [1023:0] i_rf_regs,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic [31:0]   o_cycle_count,
  output logic          o_halted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  localparam logic [7:0] CMD_RUN  = 8'h72;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;

`ifdef DBG_CYCLE_HEADER_EN
  localparam logic [7:0] DUMP_LAST = 8'd131;

  // Byte idx of the dump stream: 4 header bytes of the cycle count, then regs.
  function automatic logic [7:0] dump_byte(input logic [7:0]    idx,
                                           input logic [1023:0] regs,
                                           input logic [31:0]   cnt);
    logic [31:0]   cnt_sh;
    logic [1023:0] reg_sh;
    logic [6:0]    rb;
    logic [7:0]    b;
    cnt_sh = cnt >> {idx[1:0], 3'b000};
    // idx is 4..131 in the register part, so the low 7 bits of idx-4 suffice
    rb     = idx[6:0] - 7'd4;
    reg_sh = regs >> {rb, 3'b000};
    if (idx < 8'd4) begin
      b = cnt_sh[7:0];
    end else begin
      b = reg_sh[7:0];
    end
    return b;
  endfunction
`else
  localparam logic [7:0] DUMP_LAST = 8'd127;

  // Register n byte k sits at flat byte 4n+k, i.e. bits [8*idx +: 8].
  function automatic logic [7:0] dump_byte(input logic [6:0]    idx,
                                           input logic [1023:0] regs);
    logic [1023:0] reg_sh;
    reg_sh = regs >> {idx, 3'b000};
    return reg_sh[7:0];
  endfunction
`endif

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  byte_idx_r;
  logic [7:0]  byte_idx_nxt_s;
  logic        cmd_ready_r;
  logic        cmd_ready_nxt_s;
  logic        pipe_enable_r;
  logic        pipe_enable_nxt_s;
  logic        tx_valid_r;
  logic        tx_valid_nxt_s;
  logic [7:0]  tx_data_r;
  logic [7:0]  tx_data_nxt_s;
  logic [31:0] cycle_count_r;
  logic [31:0] cycle_count_nxt_s;
  logic        halted_r;
  logic        halted_nxt_s;
  logic        cmd_fire_s;
  logic        tx_fire_s;
  logic        dump_last_s;
  logic [7:0]  next_byte_s;

  // cmd_ready_r is high exactly in IDLE, so a fire can only happen there
  assign cmd_fire_s  = i_cmd_valid & cmd_ready_r;
  assign tx_fire_s   = tx_valid_r & i_tx_ready;
  assign dump_last_s = (byte_idx_r == DUMP_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          case (i_cmd)
            CMD_RUN: begin
              if (!halted_r) begin
                state_nxt_s = ST_RUN;
              end else begin
                state_nxt_s = ST_IDLE;
              end
            end
            CMD_STEP: begin
              if (!halted_r) begin
                state_nxt_s = ST_STEP;
              end else begin
                state_nxt_s = ST_IDLE;
              end
            end
            CMD_DUMP: state_nxt_s = ST_DUMP;
            default:  state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_nxt_s = ST_DUMP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STEP: state_nxt_s = ST_DUMP;
      ST_DUMP: begin
        if (tx_fire_s && dump_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DUMP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered from the next state
  always_comb begin
    cmd_ready_nxt_s   = (state_nxt_s == ST_IDLE);
    pipe_enable_nxt_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_STEP);
    tx_valid_nxt_s    = (state_nxt_s == ST_DUMP);
    cycle_count_nxt_s = cycle_count_r + {31'd0, pipe_enable_r};
    // pipe_enable_r is low in IDLE and DUMP, which masks i_halt there
    halted_nxt_s      = halted_r | (pipe_enable_r & i_halt);

    if (state_r == ST_DUMP) begin
      if (tx_fire_s) begin
        if (dump_last_s) begin
          byte_idx_nxt_s = 8'd0;
        end else begin
          byte_idx_nxt_s = byte_idx_r + 8'd1;
        end
      end else begin
        byte_idx_nxt_s = byte_idx_r;
      end
    end else begin
      byte_idx_nxt_s = 8'd0;
    end

`ifdef DBG_CYCLE_HEADER_EN
    // The counter cannot move while in DUMP, so its next value is the
    // value frozen at DUMP entry for the whole dump.
    next_byte_s = dump_byte(byte_idx_nxt_s, i_rf_regs, cycle_count_nxt_s);
`else
    next_byte_s = dump_byte(byte_idx_nxt_s[6:0], i_rf_regs);
`endif

    // Load a new byte on dump entry or after a transfer; hold it during stalls
    if (state_nxt_s == ST_DUMP) begin
      if ((state_r != ST_DUMP) || tx_fire_s) begin
        tx_data_nxt_s = next_byte_s;
      end else begin
        tx_data_nxt_s = tx_data_r;
      end
    end else begin
      tx_data_nxt_s = 8'h00;
    end
  end

  // Registered outputs, byte index, cycle counter and halt flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_r   <= 1'b1;
      pipe_enable_r <= 1'b0;
      tx_valid_r    <= 1'b0;
      tx_data_r     <= 8'h00;
      cycle_count_r <= 32'd0;
      halted_r      <= 1'b0;
      byte_idx_r    <= 8'd0;
    end else begin
      cmd_ready_r   <= cmd_ready_nxt_s;
      pipe_enable_r <= pipe_enable_nxt_s;
      tx_valid_r    <= tx_valid_nxt_s;
      tx_data_r     <= tx_data_nxt_s;
      cycle_count_r <= cycle_count_nxt_s;
      halted_r      <= halted_nxt_s;
      byte_idx_r    <= byte_idx_nxt_s;
    end
  end

  assign o_cmd_ready   = cmd_ready_r;
  assign o_pipe_enable = pipe_enable_r;
  assign o_tx_valid    = tx_valid_r;
  assign o_tx_data     = tx_data_r;
  assign o_cycle_count = cycle_count_r;
  assign o_halted      = halted_r;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_debug_ctrl
//
// Directed bench for pipeline_debug_ctrl. A transaction-level model (mode,
// cycle count, halted flag and a queue of bytes still to be dumped) predicts
// every output each cycle; directed tests add literal expectations.
// Honours DBG_CYCLE_HEADER_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pipeline_debug_ctrl;

`ifdef DBG_CYCLE_HEADER_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam int LEN = 128 + HDR;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid;
  logic [7:0]    i_cmd;
  logic          o_cmd_ready;
  logic          i_halt;
  logic          o_pipe_enable;
  logic [1023:0] i_rf_regs;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic [31:0]   o_cycle_count;
  logic          o_halted;

  pipeline_debug_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd         (i_cmd),
    .o_cmd_ready   (o_cmd_ready),
    .i_halt        (i_halt),
    .o_pipe_enable (o_pipe_enable),
    .i_rf_regs     (i_rf_regs),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_cycle_count (o_cycle_count),
    .o_halted      (o_halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] rf [32];
  int          m_mode = 0;      // 0 idle, 1 run, 2 step, 3 dump
  logic [31:0] m_count = 32'd0;
  bit          m_halted = 1'b0;
  logic [7:0]  m_q [$];

  function automatic void m_start_dump();
    m_q.delete();
    if (HDR == 4) begin
      for (int k = 0; k < 4; k++) m_q.push_back(m_count[8*k +: 8]);
    end
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 4; k++) m_q.push_back(rf[r][8*k +: 8]);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = 0; m_count = 32'd0; m_halted = 1'b0; m_q.delete();
      end else begin
        case (m_mode)
          0: if (i_cmd_valid) begin
               if (i_cmd == 8'h72 && !m_halted) m_mode = 1;
               else if (i_cmd == 8'h73 && !m_halted) m_mode = 2;
               else if (i_cmd == 8'h64) begin m_mode = 3; m_start_dump(); end
             end
          1: begin
               m_count = m_count + 32'd1;
               if (i_halt) begin m_halted = 1'b1; m_mode = 3; m_start_dump(); end
             end
          2: begin
               m_count = m_count + 32'd1;
               if (i_halt) m_halted = 1'b1;
               m_mode = 3; m_start_dump();
             end
          3: if (i_tx_ready) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) m_mode = 0;
             end
          default: m_mode = 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare, stall check and capture ----------------
  logic [7:0] cap [$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cmd_ready", o_cmd_ready, (m_mode == 0));
        chk("pipe_enable", o_pipe_enable, (m_mode == 1 || m_mode == 2));
        chk("tx_valid", o_tx_valid, (m_mode == 3));
        chk("cycle_count", o_cycle_count, m_count);
        chk("halted", o_halted, m_halted);
        if (m_mode == 3 && m_q.size() > 0) chk("tx_data", o_tx_data, m_q[0]);
        if (prev_stall) chk("stall_hold", o_tx_data, prev_data);
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
        if (o_tx_valid && i_tx_ready) cap.push_back(o_tx_data);
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- TX ready driver ----------------
  bit rdy_mode = 1'b0;
  int ph = 0;
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rdy_mode) begin
        i_tx_ready = (ph == 0);
        ph = (ph + 1) % 4;
      end else begin
        i_tx_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      done = o_cmd_ready;
    end
    chk(name, done, 1'b1);
  endtask

  logic [7:0] ref_dump [$];

  initial begin
    rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd = 8'h00;
    i_halt = 1'b0;
    for (int n = 0; n < 32; n++) begin
      rf[n] = n * 10;
      i_rf_regs[32*n +: 32] = n * 10;
    end
    #3;
    chk("rst_cmd_ready", o_cmd_ready, 1'b1);
    chk("rst_pipe_enable", o_pipe_enable, 1'b0);
    chk("rst_tx_valid", o_tx_valid, 1'b0);
    chk("rst_tx_data", o_tx_data, 8'h00);
    chk("rst_cycle_count", o_cycle_count, 32'd0);
    chk("rst_halted", o_halted, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Unknown command in IDLE is consumed without effect
    send_cmd(8'h41);
    chk("bad_cmd_ready", o_cmd_ready, 1'b1);
    chk("bad_cmd_pipe", o_pipe_enable, 1'b0);
    chk("bad_cmd_txv", o_tx_valid, 1'b0);

    // Plain dump; an 'r' is presented mid-dump and must not be taken
    cap.delete();
    send_cmd(8'h64);
    chk("dump_first_valid", o_tx_valid, 1'b1);
    repeat (5) step();
    i_cmd_valid = 1'b1; i_cmd = 8'h72;
    repeat (3) step();
    i_cmd_valid = 1'b0;
    wait_idle("dump1_done");
    chk("dump1_len", cap.size(), LEN);
    chk("dump1_b0", cap[HDR+0], 8'h00);
    chk("dump1_b3", cap[HDR+3], 8'h00);
    chk("dump1_b4", cap[HDR+4], 8'h0A);
    chk("dump1_b5", cap[HDR+5], 8'h00);
    chk("dump1_b124", cap[HDR+124], 8'h36);
    chk("dump1_b125", cap[HDR+125], 8'h01);
    chk("dump1_count", o_cycle_count, 32'd0);
    ref_dump = cap;
    step();
    chk("dump1_txv_low", o_tx_valid, 1'b0);

    // Single step: one enabled cycle, then a dump
    cap.delete();
    send_cmd(8'h73);
    chk("step_pipe_on", o_pipe_enable, 1'b1);
    step();
    chk("step_pipe_off", o_pipe_enable, 1'b0);
    chk("step_count", o_cycle_count, 32'd1);
    chk("step_dump_valid", o_tx_valid, 1'b1);
    wait_idle("step_done");
    chk("step_len", cap.size(), LEN);
    chk("step_ready", o_cmd_ready, 1'b1);

    // Reset, run, HALT on the 10th enabled cycle
    rst = 1'b1; step(); rst = 1'b0;
    send_cmd(8'h72);
    repeat (9) step();
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;
    chk("run_count", o_cycle_count, 32'd10);
    chk("run_halted", o_halted, 1'b1);
    chk("run_pipe_off", o_pipe_enable, 1'b0);
    chk("run_dump_valid", o_tx_valid, 1'b1);
    wait_idle("run_done");

    // After HALT, 'r' and 's' are ignored
    send_cmd(8'h72);
    chk("halted_r_pipe", o_pipe_enable, 1'b0);
    chk("halted_r_ready", o_cmd_ready, 1'b1);
    send_cmd(8'h73);
    chk("halted_s_pipe", o_pipe_enable, 1'b0);
    chk("halted_s_ready", o_cmd_ready, 1'b1);

    // Dump with TX ready 1 high / 3 low
    cap.delete();
    rdy_mode = 1'b1;
    send_cmd(8'h64);
    wait_idle("slow_done");
    rdy_mode = 1'b0;
    chk("slow_len", cap.size(), LEN);
`ifdef DBG_CYCLE_HEADER_EN
    chk("slow_hdr0", cap[0], 8'h0A);
`endif
    for (int i = HDR; i < LEN; i++) chk("slow_byte", cap[i], ref_dump[i]);

    // Reset after 50 bytes of a dump
    cap.delete();
    send_cmd(8'h64);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
        if (cap.size() >= 50) got = 1'b1;
        else step();
      end
      chk("mid_50_reached", got, 1'b1);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", o_cmd_ready, 1'b1);
    chk("mid_rst_pipe", o_pipe_enable, 1'b0);
    chk("mid_rst_txv", o_tx_valid, 1'b0);
    chk("mid_rst_txd", o_tx_data, 8'h00);
    chk("mid_rst_count", o_cycle_count, 32'd0);
    chk("mid_rst_halted", o_halted, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Restarted dump begins at byte 0
    cap.delete();
    send_cmd(8'h64);
    wait_idle("restart_done");
    chk("restart_len", cap.size(), LEN);
    for (int i = 0; i < LEN; i++) chk("restart_byte", cap[i], ref_dump[i]);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_debug_ctrl.md
PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port i_cmd_valid, input, 1, command byte present.
REQ-004 SHALL have port i_cmd, input, 8, command: 0x72 'r' run, 0x73 's' step, 0x64 'd' dump.
REQ-005 SHALL have port o_cmd_ready, output, 1, command accepted when i_cmd_valid and o_cmd_ready both high at clk edge.
REQ-006 SHALL have port i_halt, input, 1, pipeline retired HALT instruction.
REQ-007 SHALL have port o_pipe_enable, output, 1, global enable to PC, IF/ID and all pipeline registers.
REQ-008 SHALL have port i_rf_regs, input, 1024, flattened register file, reg n at bits [32n+31:32n].
REQ-009 SHALL have ports o_tx_data (output, 8), o_tx_valid (output, 1) and i_tx_ready (input, 1), byte stream to UART TX; transfer when valid and ready both high.
REQ-010 SHALL have port o_cycle_count, output, 32, number of enabled pipeline cycles.
REQ-011 SHALL have port o_halted, output, 1, sticky flag: program reached HALT.

Function
REQ-012 SHALL implement states IDLE, RUN, STEP, DUMP; o_pipe_enable high only in RUN and STEP.
REQ-013 IDLE: o_cmd_ready=1; accepted 'r' -> RUN, 's' -> STEP, 'd' -> DUMP; any other byte consumed and ignored.
REQ-014 IDLE with o_halted=1: 'r' and 's' consumed and ignored; only 'd' acts.
REQ-015 o_cmd_ready SHALL be 0 outside IDLE; commands presented there are not buffered.
REQ-016 RUN: o_pipe_enable=1 each cycle; on clk edge with i_halt=1 -> DUMP and set o_halted; o_pipe_enable low from the next cycle.
REQ-017 STEP: o_pipe_enable=1 for exactly one cycle, then DUMP; i_halt sampled in that cycle sets o_halted.
REQ-018 i_halt SHALL be ignored in IDLE and DUMP.
REQ-019 o_cycle_count SHALL increment by 1 on every edge where o_pipe_enable=1, wrapping 0xFFFFFFFF -> 0.
REQ-020 DUMP: stream register 0..31, each 4 bytes LSB first, read live from i_rf_regs (stable since pipeline disabled); byte index counter advances only on accepted transfer.
REQ-021 o_tx_valid SHALL be high throughout DUMP until last byte accepted; o_tx_data SHALL stay stable while o_tx_valid=1 and i_tx_ready=0.
REQ-022 After last byte accepted -> IDLE on the same edge; o_tx_valid low the following cycle.
REQ-023 Dump latency: first byte valid in the cycle after DUMP entry; no idle cycles between bytes when i_tx_ready held high.

Reset
REQ-024 rst SHALL force IDLE, o_cmd_ready=1, o_pipe_enable=0, o_tx_valid=0, o_tx_data=0, o_cycle_count=0, o_halted=0, byte index=0, immediately and independent of clk.
REQ-025 rst asserted mid-RUN or mid-DUMP SHALL abort the operation; no partial state survives deassertion.

Configuration
REQ-026 Macro DBG_CYCLE_HEADER_EN defined: dump SHALL begin with 4 bytes of o_cycle_count LSB first (value frozen at DUMP entry), total 132 bytes.
REQ-027 Macro DBG_CYCLE_HEADER_EN undefined: dump SHALL be 128 register bytes only; o_cycle_count still counts.

Verification
REQ-028 rst, i_rf_regs reg n = n*10, cmd 'd', i_tx_ready=1 -> 128 bytes (132 with header, count 0) beginning 0x00 x4, 0x0A,0x00,0x00,0x00; back to IDLE.
REQ-029 cmd 's' -> o_pipe_enable high exactly 1 cycle, o_cycle_count=1, then full dump, then IDLE with o_cmd_ready=1.
REQ-030 cmd 'r', i_halt pulsed on 10th enabled cycle -> o_cycle_count=10, o_halted=1, dump follows; subsequent 'r' and 's' ignored, 'd' dumps again.
REQ-031 DUMP with i_tx_ready toggling 1 cycle high / 3 low -> byte order and values identical to REQ-028, o_tx_data stable during every stall.
REQ-032 rst pulsed after 50 bytes of dump -> all outputs at REQ-024 values immediately; next 'd' restarts at byte 0.
REQ-033 cmd 0x41 in IDLE and 'r' while in DUMP -> both without effect; state sequence unchanged.
